regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RISC-V core; successor to the fixed 32x32 2R1W file.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_wr_arb.sv | 29 ++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state encoding
// and the per-entry initialisation value.
package regfile_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int INIT_MODE_ZERO  = 0;
    localparam int INIT_MODE_INDEX = 1;
    localparam int INIT_VAL_W      = 64;

    function automatic logic [INIT_VAL_W-1:0] init_val(input int idx, input int mode);
        if (mode == INIT_MODE_INDEX) begin
            init_val = INIT_VAL_W'(idx);
        end else begin
            init_val = '0;
        end
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves the NUM_WR write ports into one write enable and data word per entry.
// Ports are scanned in ascending order so the highest-index port wins a collision.
module regfile_wr_arb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_WR = 1,
    parameter int AW     = 5
) (
    input  logic [NUM_WR-1:0]      i_wrEn,
    input  logic [NUM_WR*AW-1:0]   i_wrAddr,
    input  logic [NUM_WR*XLEN-1:0] i_wrData,
    output logic [NREGS-1:0]       o_entryWe,
    output logic [XLEN-1:0]        o_entryData [NREGS]
);

    always_comb begin
        o_entryWe = '0;
        for (int e = 0; e < NREGS; e++) begin
            o_entryData[e] = '0;
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (i_wrEn[p]) begin
                o_entryWe[i_wrAddr[p*AW +: AW]]   = 1'b1;
                o_entryData[i_wrAddr[p*AW +: AW]] = i_wrData[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with a sequential init engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_req,
    output logic                   ready,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data
);

    state_t          r_state;
    state_t          w_nextState;
    logic [AW-1:0]   r_initCnt;
    logic [AW-1:0]   w_nextCnt;
    logic [XLEN-1:0] r_mem [NREGS];
    logic [NUM_WR-1:0] w_portEn;
    logic [NREGS-1:0]  w_entryWe;
    logic [XLEN-1:0]   w_entryData [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_initCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_initCnt <= w_nextCnt;
        end
    end

    // The counter stops on a terminal compare rather than wrapping.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_initCnt;
        case (r_state)
            ST_INIT: begin
                if (r_initCnt == AW'(NREGS-1)) begin
                    w_nextState = ST_RUN;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_initCnt + AW'(1);
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    w_nextState = ST_INIT;
                    w_nextCnt   = '0;
                end
            end
            default: begin
                w_nextState = ST_INIT;
                w_nextCnt   = '0;
            end
        endcase
    end

    assign ready    = (r_state == ST_RUN);
    assign w_portEn = (r_state == ST_RUN) ? wr_en : '0;

    regfile_wr_arb #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR),
        .AW     (AW)
    ) u_wrArb (
        .i_wrEn      (w_portEn),
        .i_wrAddr    (wr_addr),
        .i_wrData    (wr_data),
        .o_entryWe   (w_entryWe),
        .o_entryData (w_entryData)
    );

    // Storage has no reset; contents are rebuilt by the init engine instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (r_state == ST_INIT) begin
                if (r_initCnt == AW'(i)) begin
                    r_mem[i] <= XLEN'(init_val(i, INIT_MODE));
                end
            end else if (w_entryWe[i] && !(ZERO_REG != 0 && i == 0)) begin
                r_mem[i] <= w_entryData[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p*XLEN +: XLEN] = r_mem[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (r_state == ST_RUN && wr_en[w] &&
                    wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]) begin
                    rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                end
            end
`else
`endif
            if (r_state != ST_RUN || (ZERO_REG != 0 && rd_addr[p*AW +: AW] == '0)) begin
                rd_data[p*XLEN +: XLEN] = '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table, hand-written multi-cycle sequences
// and randomized traffic against a simple array model of the register file.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clearReq = 1'b0;
    logic        ready;
    logic [1:0]  wrEn = '0;
    logic [9:0]  wrAddr = '0;
    logic [63:0] wrData = '0;
    logic [9:0]  rdAddr = '0;
    logic [63:0] rdData;

    logic        zClear = 1'b0;
    logic        zReady;
    logic [0:0]  zWrEn = '0;
    logic [2:0]  zWrAddr = '0;
    logic [31:0] zWrData = '0;
    logic [2:0]  zRdAddr = '0;
    logic [31:0] zRdData;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];
    logic [31:0] exp0;
    logic [31:0] exp1;

    typedef struct {
        logic [1:0]  en;
        int          a0;
        logic [31:0] d0;
        int          a1;
        logic [31:0] d1;
        int          r0;
        int          r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .INIT_MODE(1)
    ) u_dut (
        .clk(clk), .reset(reset), .clear_req(clearReq), .ready(ready),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_addr(rdAddr), .rd_data(rdData)
    );

    regfile_mp #(
        .XLEN(32), .NREGS(8), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0), .INIT_MODE(0)
    ) u_dutZ (
        .clk(clk), .reset(reset), .clear_req(zClear), .ready(zReady),
        .wr_en(zWrEn), .wr_addr(zWrAddr), .wr_data(zWrData),
        .rd_addr(zRdAddr), .rd_data(zRdData)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 32; i++) model[i] = 32'(i);
    endtask

    function automatic logic [31:0] refRead(input int addr, input logic [1:0] en, input int a0,
                                            input logic [31:0] d0, input int a1, input logic [31:0] d1);
        if (addr == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (en[1] && a1 == addr) return d1;
        if (en[0] && a0 == addr) return d0;
`endif
        return model[addr];
    endfunction

    // Drives one cycle of traffic at the negedge, computes the expected reads from the
    // pre-write model, then records the writes that commit at the following posedge.
    task automatic applyStimulus(input logic [1:0] en, input int a0, input logic [31:0] d0,
                                 input int a1, input logic [31:0] d1, input int r0, input int r1);
        logic [4:0] wa0, wa1, ra0, ra1;
        @(negedge clk);
        wa0 = 5'(a0); wa1 = 5'(a1); ra0 = 5'(r0); ra1 = 5'(r1);
        wrEn   = en;
        wrAddr = {wa1, wa0};
        wrData = {d1, d0};
        rdAddr = {ra1, ra0};
        exp0 = refRead(r0, en, a0, d0, a1, d1);
        exp1 = refRead(r1, en, a0, d0, a1, d1);
        if (en[0] && a0 != 0) model[a0] = d0;
        if (en[1] && a1 != 0) model[a1] = d1;
        #1;
    endtask

    task automatic waitReady(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!ready && cycles < 100);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int r0, r1;
        logic [1:0] en;
        int a0, a1;
        logic [31:0] d0, d1;

        vecs[0] = '{2'b01, 7,  32'hDEADBEEF, 0,  32'h0,        5,  31, 32'd5,        32'd31};
        vecs[1] = '{2'b00, 0,  32'h0,        0,  32'h0,        7,  8,  32'hDEADBEEF, 32'd8};
        vecs[2] = '{2'b01, 0,  32'h00001234, 0,  32'h0,        0,  7,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{2'b00, 0,  32'h0,        0,  32'h0,        0,  1,  32'h0,        32'd1};
        vecs[4] = '{2'b11, 13, 32'h13131313, 12, 32'hCAFEF00D, 11, 14, 32'd11,       32'd14};
        vecs[5] = '{2'b00, 0,  32'h0,        0,  32'h0,        12, 13, 32'hCAFEF00D, 32'h13131313};
        vecs[6] = '{2'b01, 31, 32'hFFFFFFFF, 0,  32'h0,        30, 2,  32'd30,       32'd2};
        vecs[7] = '{2'b00, 0,  32'h0,        0,  32'h0,        31, 7,  32'hFFFFFFFF, 32'hDEADBEEF};

        // Reset state
        rdAddr = {5'd31, 5'd5};
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ready", 32'(ready), 32'h0);
        checkOutput("reset rd0", rdData[31:0], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        waitReady(cycles);
        checkOutput("init cycles", 32'(cycles), 32'd32);
        checkOutput("ready after init", 32'(ready), 32'h1);
        checkOutput("zdut ready", 32'(zReady), 32'h1);
        resetModel();

        // Vector table
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].en, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1, vecs[i].r0, vecs[i].r1);
            checkOutput($sformatf("vec%0d rd0", i), rdData[31:0], vecs[i].e0);
            checkOutput($sformatf("vec%0d rd1", i), rdData[63:32], vecs[i].e1);
        end

        // Write-port collision, with and without bypass
        applyStimulus(2'b11, 3, 32'hA, 3, 32'hB, 3, 0);
`ifdef REGFILE_BYPASS_EN
        checkOutput("collision same-cycle", rdData[31:0], 32'hB);
`else
        checkOutput("collision same-cycle", rdData[31:0], 32'h3);
`endif
        checkOutput("collision rd x0", rdData[63:32], 32'h0);
        applyStimulus(2'b00, 0, 0, 0, 0, 3, 0);
        checkOutput("collision winner", rdData[31:0], 32'hB);
        applyStimulus(2'b11, 0, 32'h77, 0, 32'h88, 0, 3);
        checkOutput("bypass never x0", rdData[31:0], 32'h0);
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 3);
        checkOutput("x0 still zero", rdData[31:0], 32'h0);

        // Ordinary entry 0 in the ZERO_REG=0 build
        @(negedge clk);
        zRdAddr = 3'd3;
        zWrEn = 1'b1; zWrAddr = 3'd0; zWrData = 32'h1234;
        #1;
        checkOutput("zdut init zero", zRdData, 32'h0);
        @(negedge clk);
        zWrEn = 1'b0; zRdAddr = 3'd0;
        #1;
        checkOutput("zdut x0 written", zRdData, 32'h1234);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            en = 2'($urandom_range(0, 3));
            a0 = int'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, 31));
            d0 = $urandom;
            d1 = $urandom;
            r0 = ($urandom_range(0, 2) == 0) ? a0 : int'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 2) == 0) ? a1 : int'($urandom_range(0, 31));
            applyStimulus(en, a0, d0, a1, d1, r0, r1);
            checkOutput($sformatf("rand%0d rd0 x%0d", n, r0), rdData[31:0], exp0);
            checkOutput($sformatf("rand%0d rd1 x%0d", n, r1), rdData[63:32], exp1);
        end

        // Clear request: same-cycle write, ignored writes/clears during INIT, full re-init
        applyStimulus(2'b01, 9, 32'h55, 0, 0, 0, 0);
        applyStimulus(2'b00, 0, 0, 0, 0, 9, 0);
        checkOutput("pre-clear x9", rdData[31:0], 32'h55);
        @(negedge clk);
        clearReq = 1'b1;
        wrEn = 2'b01; wrAddr = {5'd0, 5'd10}; wrData = {32'h0, 32'h77};
        @(negedge clk);
        clearReq = 1'b0;
        wrEn = 2'b00;
        rdAddr = {5'd0, 5'd9};
        #1;
        checkOutput("clear ready low", 32'(ready), 32'h0);
        checkOutput("init reads zero", rdData[31:0], 32'h0);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 10) begin
                wrEn = 2'b01; wrAddr = {5'd0, 5'd3}; wrData = {32'h0, 32'hBAD};
                clearReq = 1'b1;
            end else if (cycles == 11) begin
                wrEn = 2'b00;
                clearReq = 1'b0;
            end
        end while (!ready && cycles < 100);
        checkOutput("clear init cycles", 32'(cycles), 32'd32);
        resetModel();
        applyStimulus(2'b00, 0, 0, 0, 0, 9, 3);
        checkOutput("post-clear x9", rdData[31:0], 32'd9);
        checkOutput("init ignores wr x3", rdData[63:32], 32'd3);
        applyStimulus(2'b00, 0, 0, 0, 0, 10, 7);
        checkOutput("post-clear x10", rdData[31:0], 32'd10);
        checkOutput("post-clear x7", rdData[63:32], 32'd7);

        // Asynchronous reset in RUN drops ready without a clock edge
        applyStimulus(2'b01, 20, 32'h2020, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset ready", 32'(ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset part way through INIT restarts the count
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid-init reset ready", 32'(ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        waitReady(cycles);
        checkOutput("restart init cycles", 32'(cycles), 32'd32);
        resetModel();
        applyStimulus(2'b00, 0, 0, 0, 0, 20, 31);
        checkOutput("reinit x20", rdData[31:0], 32'd20);
        checkOutput("reinit x31", rdData[63:32], 32'd31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
